sd_spi_cmd_sequencer: RTL and testbench
=======================================

// Module: sd_spi_cmd_sequencer
// PURPOSE
//  Bus-master sequencer that drives the SPI controller's register port to execute one SD-card
//  SPI-mode command: CS assert, 6-byte command frame, R1 poll, optional 512-byte block read.
//  Sits between a boot loader/DMA requester and the SPI controller; the CPU stays off the port while busy.
//  Block data is streamed out byte-by-byte. A completion pulse carries R1 and an error code.
// PARAMETERS
//  R1_TRIES     8      max 0xFF filler bytes clocked while waiting for R1 (bit7==0)
//  TOKEN_TRIES  1024   max filler bytes clocked while waiting for data token 0xFE
//  BLOCK_LEN    512    data bytes per block read
//  SPI_BASE     32'h0  base address of the SPI controller: DATA +0x0, STATUS +0x4 (bit0 busy), CS +0x8
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   asynchronous active-low reset
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   high only in IDLE; command accepted when cmd_valid&&cmd_ready
//  cmd_index    in   6   SD command index (frame byte0 = {2'b01,cmd_index})
//  cmd_arg      in   32  argument, sent MSB first (frame bytes 1..4)
//  cmd_crc      in   8   frame byte5 as given (caller supplies {crc7,1'b1})
//  cmd_rd_block in   1   1: perform token wait + BLOCK_LEN data phase after R1
//  done         out  1   one-cycle pulse at end of sequence
//  r1           out  8   last R1 received; held until next accept
//  err          out  2   0 ok, 1 R1 timeout, 2 token timeout, 3 error token (non-0xFF, non-0xFE)
//  crc_err      out  1   block CRC mismatch (see CONFIGURATION); valid with done
//  data_valid   out  1   one-cycle pulse per received block byte
//  data_byte    out  8   block byte, valid with data_valid
//  spi_valid    out  1   master request to SPI controller
//  spi_addr     out  32  SPI_BASE + register offset
//  spi_wdata    out  32  write data
//  spi_wstrb    out  4   4'hF write, 4'h0 read
//  spi_ready    in   1   controller acknowledge (single-cycle)
//  spi_rdata    in   32  controller read data
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE; byte engine idle; counters 0.
//  Bus rule: spi_valid/addr/wdata/wstrb registered; spi_valid cleared on the same edge spi_ready is
//   sampled high (never held past ready -> no double access). One access in flight max.
//  Byte engine (xfer byte B): P1 read STATUS until bit0==0 -> W write DATA=B -> P2 read STATUS until
//   bit0==0 -> R read DATA, rx=rdata[7:0]. No busy timeout. Writes never issued while busy.
//  Main FSM: IDLE -accept-> latch cmd, clear r1/err/crc_err -> CS_LO (write CS=0) -> PRE (xfer 0xFF)
//   -> SEND (xfer 6 frame bytes, byte0 first) -> R1W (xfer 0xFF; rx[7]==0 -> r1=rx; else count)
//   -> [cmd_rd_block && r1==8'h00] TOKW : CS_HI.
//  R1W: R1_TRIES fillers with rx[7]==1 -> err=1, go CS_HI.
//  TOKW: xfer 0xFF; rx==0xFE -> DATA; rx==0xFF -> count, TOKEN_TRIES reached -> err=2, CS_HI;
//   other -> r1 unchanged, err=3, CS_HI.
//  DATA: BLOCK_LEN xfers of 0xFF; data_valid pulses the cycle after each DATA read completes;
//   byte counter 0..BLOCK_LEN-1, no wrap. Then CRC: 2 xfers (hi, lo).
//  CS_HI (write CS=1) -> TRAIL (xfer 0xFF, 8 extra clocks) -> DONE: done=1 one cycle -> IDLE.
//  cmd_rd_block with r1!=0: data phase skipped, err=0; caller inspects r1.
//  cmd_valid while not IDLE: ignored (cmd_ready=0). Reset mid-sequence: immediate IDLE, spi_valid=0,
//   no CS release issued (controller shares resetn and returns cs_n=1 itself).
//  Clock divider register never written by this block.
// CONFIGURATION
//  SEQ_CRC16_CHECK_EN defined: CRC16-CCITT (poly 0x1021, init 0x0000) over the BLOCK_LEN data bytes,
//   compared to the received {hi,lo}; crc_err=1 on mismatch (err unchanged).
//  Not defined: CRC bytes clocked and discarded; crc_err tied 0.
// TESTING (SPI controller instance, divider=0, SD slave model on miso)
//  CMD0 arg 0 crc 0x95, slave R1=0x01 on 2nd filler -> frame 40 00 00 00 00 95 on mosi; r1=0x01, err=0, done once.
//  CMD17 arg 0x0000_0200, R1=0x00, token after 3 fillers, data i&0xFF -> 512 data_valid, bytes 00..FF,00..FF; err=0.
//  Slave never answers (miso=1) -> exactly 8 R1 fillers, err=1, CS high, done.
//  CMD17 token 0x05 -> err=3, no data_valid; token never -> 1024 fillers, err=2.
//  SEQ_CRC16_CHECK_EN: correct CRC -> crc_err=0; flip one CRC bit -> crc_err=1; without macro -> 0.
//  resetn low mid-DATA -> cmd_ready=1, spi_valid=0 same cycle; next CMD0 completes normally.

Source files
------------

// File: rtl/sd_spi_cmd_sequencer.sv
// sd_spi_cmd_sequencer: bus master that runs one SD-card SPI-mode command through the
// register port of an SPI controller. The sequence is CS low, one filler byte, the 6-byte
// frame, the R1 poll, an optional token wait with a BLOCK_LEN data phase and CRC bytes,
// then CS high, one trailing filler byte, and a done pulse.
// Optional feature: define SEQ_CRC16_CHECK_EN to check the block CRC16-CCITT (crc_err).
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only while idle)
//   cmd_index/cmd_arg/cmd_crc          frame contents; cmd_rd_block selects a block read
//   done, r1, err, crc_err             completion pulse and status (held until next accept)
//   data_valid, data_byte              streamed block bytes
//   spi_valid/addr/wdata/wstrb         register-port request (wstrb F = write, 0 = read)
//   spi_ready/spi_rdata                single-cycle acknowledge and read data
module sd_spi_cmd_sequencer #(
    parameter int unsigned R1_TRIES    = 8,
    parameter int unsigned TOKEN_TRIES = 1024,
    parameter int unsigned BLOCK_LEN   = 512,
    parameter logic [31:0] SPI_BASE    = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [7:0]  cmd_crc,
    input  logic        cmd_rd_block,
    output logic        done,
    output logic [7:0]  r1,
    output logic [1:0]  err,
    output logic        crc_err,
    output logic        data_valid,
    output logic [7:0]  data_byte,
    output logic        spi_valid,
    output logic [31:0] spi_addr,
    output logic [31:0] spi_wdata,
    output logic [3:0]  spi_wstrb,
    input  logic        spi_ready,
    input  logic [31:0] spi_rdata
);

    localparam int unsigned CNT_W = $clog2(TOKEN_TRIES + BLOCK_LEN + R1_TRIES + 8);
    localparam logic [31:0] ADDR_DATA = SPI_BASE + 32'h0;
    localparam logic [31:0] ADDR_STAT = SPI_BASE + 32'h4;
    localparam logic [31:0] ADDR_CS   = SPI_BASE + 32'h8;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_LO, S_PRE, S_SEND, S_R1W, S_TOKW,
        S_DATA, S_CRC, S_CS_HI, S_TRAIL, S_DONE
    } state_t;

    // Byte engine: poll idle, write byte, poll idle, read received byte.
    typedef enum logic [2:0] {E_IDLE, E_P1, E_W, E_P2, E_R} eng_t;

    state_t             state, state_n;
    eng_t               eng, eng_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [7:0]         tx_byte, tx_n;
    logic [5:0]         idx_q;
    logic [31:0]        arg_q;
    logic [7:0]         crc_q;
    logic               rd_q;

    logic               valid_n;
    logic [31:0]        addr_n, wdata_n;
    logic [3:0]         wstrb_n;
    logic [7:0]         r1_n, db_n;
    logic [1:0]         err_n;
    logic               dv_n;

    logic               accept, ack, xfer_done;
    logic [7:0]         rx;
    logic               unused_rdata;

    assign accept       = cmd_valid && cmd_ready;
    assign ack          = spi_valid && spi_ready;
    assign xfer_done    = ack && (eng == E_R);
    assign rx           = spi_rdata[7:0];
    assign unused_rdata = ^spi_rdata[31:8];

    // Frame byte i of the latched command (byte0 first on the wire).
    function automatic logic [7:0] frame_byte(input logic [2:0] i);
        case (i)
            3'd0:    frame_byte = {2'b01, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            default: frame_byte = crc_q;
        endcase
    endfunction

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            eng        <= E_IDLE;
            cnt        <= '0;
            tx_byte    <= '0;
            idx_q      <= '0;
            arg_q      <= '0;
            crc_q      <= '0;
            rd_q       <= 1'b0;
            spi_valid  <= 1'b0;
            spi_addr   <= '0;
            spi_wdata  <= '0;
            spi_wstrb  <= '0;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            r1         <= '0;
            err        <= '0;
            data_valid <= 1'b0;
            data_byte  <= '0;
        end else begin
            state      <= state_n;
            eng        <= eng_n;
            cnt        <= cnt_n;
            tx_byte    <= tx_n;
            spi_valid  <= valid_n;
            spi_addr   <= addr_n;
            spi_wdata  <= wdata_n;
            spi_wstrb  <= wstrb_n;
            cmd_ready  <= (state_n == S_IDLE);
            done       <= (state_n == S_DONE);
            r1         <= r1_n;
            err        <= err_n;
            data_valid <= dv_n;
            data_byte  <= db_n;
            if (accept) begin
                idx_q <= cmd_index;
                arg_q <= cmd_arg;
                crc_q <= cmd_crc;
                rd_q  <= cmd_rd_block;
            end
        end
    end

    // Next state: byte-engine phase advance, then sequence decisions that may start a new byte.
    always_comb begin
        state_n = state;
        eng_n   = eng;
        cnt_n   = cnt;
        tx_n    = tx_byte;
        if (ack) begin
            case (eng)
                E_P1:    if (!spi_rdata[0]) eng_n = E_W;
                E_W:     eng_n = E_P2;
                E_P2:    if (!spi_rdata[0]) eng_n = E_R;
                E_R:     eng_n = E_IDLE;
                default: ;
            endcase
        end
        case (state)
            S_IDLE:  if (accept) begin state_n = S_CS_LO; cnt_n = '0; end
            S_CS_LO: if (ack) begin state_n = S_PRE; eng_n = E_P1; tx_n = 8'hFF; end
            S_PRE:   if (xfer_done) begin
                state_n = S_SEND; cnt_n = '0; eng_n = E_P1; tx_n = frame_byte(3'd0);
            end
            S_SEND:  if (xfer_done) begin
                eng_n = E_P1;
                if (cnt == CNT_W'(5)) begin
                    state_n = S_R1W; cnt_n = '0; tx_n = 8'hFF;
                end else begin
                    cnt_n = cnt + CNT_W'(1); tx_n = frame_byte(cnt[2:0] + 3'd1);
                end
            end
            S_R1W:   if (xfer_done) begin
                if (!rx[7]) begin
                    if (rd_q && (rx == 8'h00)) begin
                        state_n = S_TOKW; cnt_n = '0; eng_n = E_P1; tx_n = 8'hFF;
                    end else begin
                        state_n = S_CS_HI;
                    end
                end else if (cnt == CNT_W'(R1_TRIES - 1)) begin
                    state_n = S_CS_HI;
                end else begin
                    cnt_n = cnt + CNT_W'(1); eng_n = E_P1; tx_n = 8'hFF;
                end
            end
            S_TOKW:  if (xfer_done) begin
                if (rx == 8'hFE) begin
                    state_n = S_DATA; cnt_n = '0; eng_n = E_P1; tx_n = 8'hFF;
                end else if ((rx == 8'hFF) && (cnt != CNT_W'(TOKEN_TRIES - 1))) begin
                    cnt_n = cnt + CNT_W'(1); eng_n = E_P1; tx_n = 8'hFF;
                end else begin
                    state_n = S_CS_HI;
                end
            end
            S_DATA:  if (xfer_done) begin
                eng_n = E_P1; tx_n = 8'hFF;
                if (cnt == CNT_W'(BLOCK_LEN - 1)) begin
                    state_n = S_CRC; cnt_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_CRC:   if (xfer_done) begin
                if (cnt == '0) begin
                    cnt_n = CNT_W'(1); eng_n = E_P1; tx_n = 8'hFF;
                end else begin
                    state_n = S_CS_HI;
                end
            end
            S_CS_HI: if (ack) begin state_n = S_TRAIL; eng_n = E_P1; tx_n = 8'hFF; end
            S_TRAIL: if (xfer_done) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs: bus request issue/retire and status capture.
    always_comb begin
        valid_n = spi_valid;
        addr_n  = spi_addr;
        wdata_n = spi_wdata;
        wstrb_n = spi_wstrb;
        r1_n    = r1;
        err_n   = err;
        dv_n    = 1'b0;
        db_n    = data_byte;
        // Retire on the ready edge; a new request goes out only once the bus is free.
        if (ack) begin
            valid_n = 1'b0;
        end else if (!spi_valid) begin
            if (state == S_CS_LO || state == S_CS_HI) begin
                valid_n = 1'b1; addr_n = ADDR_CS; wstrb_n = 4'hF;
                wdata_n = {31'h0, state == S_CS_HI};
            end else begin
                case (eng)
                    E_P1, E_P2: begin valid_n = 1'b1; addr_n = ADDR_STAT; wstrb_n = 4'h0; end
                    E_W:  begin
                        valid_n = 1'b1; addr_n = ADDR_DATA; wstrb_n = 4'hF;
                        wdata_n = {24'h0, tx_byte};
                    end
                    E_R:  begin valid_n = 1'b1; addr_n = ADDR_DATA; wstrb_n = 4'h0; end
                    default: ;
                endcase
            end
        end
        if (accept) begin
            r1_n  = '0;
            err_n = '0;
        end
        if (xfer_done) begin
            case (state)
                S_R1W: begin
                    if (!rx[7]) r1_n = rx;
                    else if (cnt == CNT_W'(R1_TRIES - 1)) err_n = 2'd1;
                end
                S_TOKW: begin
                    if (rx == 8'hFF) begin
                        if (cnt == CNT_W'(TOKEN_TRIES - 1)) err_n = 2'd2;
                    end else if (rx != 8'hFE) begin
                        err_n = 2'd3;
                    end
                end
                S_DATA: begin dv_n = 1'b1; db_n = rx; end
                default: ;
            endcase
        end
    end

`ifdef SEQ_CRC16_CHECK_EN
    logic [15:0] blk_crc;
    logic [7:0]  crc_hi;

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // CRC16-CCITT over data bytes, compared against the received hi/lo pair.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk_crc <= '0;
            crc_hi  <= '0;
            crc_err <= 1'b0;
        end else if (accept) begin
            blk_crc <= '0;
            crc_err <= 1'b0;
        end else if (xfer_done && state == S_DATA) begin
            blk_crc <= crc16_upd(blk_crc, rx);
        end else if (xfer_done && state == S_CRC) begin
            if (cnt == '0) crc_hi <= rx;
            else           crc_err <= (blk_crc != {crc_hi, rx});
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_spi_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_sd_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic [7:0]  cmd_crc = '0;
    logic        cmd_rd_block = 1'b0;
    logic        done;
    logic [7:0]  r1;
    logic [1:0]  err;
    logic        crc_err;
    logic        data_valid;
    logic [7:0]  data_byte;
    logic        spi_valid;
    logic [31:0] spi_addr;
    logic [31:0] spi_wdata;
    logic [3:0]  spi_wstrb;
    logic        spi_ready;
    logic [31:0] spi_rdata;

    int checks = 0;
    int errors = 0;

    // slave response script
    int          r1_at = 1;
    logic [7:0]  r1_val = 8'h01;
    int          tok_at = -1;
    logic [7:0]  tok_val = 8'hFE;
    logic [15:0] crc_word = 16'h0;

    // controller/slave model state
    logic        cs_n_m;
    int          busy_cnt;
    logic [7:0]  rx_m;
    int          cs_bytes = 0;
    int          trail_bytes = 0;
    int          filler_bad = 0;
    int          bus_viol = 0;
    logic [7:0]  frame_log [0:15];

    // monitor state
    int blk_idx = 0;
    int dv_total = 0;
    int dv_bad = 0;
    int done_total = 0;

    // results captured at done
    logic [7:0] got_r1;
    logic [1:0] got_err;
    logic       got_crc_err;

    always #5 clk = ~clk;

    sd_spi_cmd_sequencer dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
        .cmd_rd_block(cmd_rd_block),
        .done(done), .r1(r1), .err(err), .crc_err(crc_err),
        .data_valid(data_valid), .data_byte(data_byte),
        .spi_valid(spi_valid), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_wstrb(spi_wstrb), .spi_ready(spi_ready), .spi_rdata(spi_rdata)
    );

    function automatic logic [15:0] crc16_ref(input int n);
        logic [15:0] c;
        logic [7:0]  d;
        c = 16'h0;
        for (int k = 0; k < n; k++) begin
            d = 8'(k);
            c = c ^ {d, 8'h00};
            for (int b = 0; b < 8; b++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // byte n since CS low: 0 = pre filler, 1..6 = frame, 7.. = fillers
    function automatic logic [7:0] miso_byte(input int n);
        int f, k, d;
        f = n - 7;
        if (f < 0 || r1_at < 0 || f < r1_at) return 8'hFF;
        if (f == r1_at) return r1_val;
        k = f - r1_at - 1;
        if (tok_at < 0 || k < tok_at) return 8'hFF;
        if (k == tok_at) return tok_val;
        d = k - tok_at - 1;
        if (d < 512) return 8'(d);
        if (d == 512) return crc_word[15:8];
        if (d == 513) return crc_word[7:0];
        return 8'hFF;
    endfunction

    // SPI controller register model with registered single-cycle ready
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spi_ready <= 1'b0;
            spi_rdata <= '0;
            cs_n_m    <= 1'b1;
            busy_cnt  <= 0;
            rx_m      <= 8'hFF;
        end else begin
            spi_ready <= 1'b0;
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (spi_valid && !spi_ready) begin
                spi_ready <= 1'b1;
                if (spi_wstrb == 4'hF && spi_addr == 32'h0) begin
                    if (busy_cnt != 0) bus_viol <= bus_viol + 1;
                    busy_cnt <= 3;
                    if (!cs_n_m) begin
                        if (cs_bytes < 16) frame_log[cs_bytes] <= spi_wdata[7:0];
                        if (cs_bytes >= 7 && spi_wdata[7:0] != 8'hFF) filler_bad <= filler_bad + 1;
                        rx_m     <= miso_byte(cs_bytes);
                        cs_bytes <= cs_bytes + 1;
                    end else begin
                        rx_m        <= 8'hFF;
                        trail_bytes <= trail_bytes + 1;
                    end
                end else if (spi_wstrb == 4'hF && spi_addr == 32'h8) begin
                    cs_n_m <= spi_wdata[0];
                    if (!spi_wdata[0]) begin
                        cs_bytes    <= 0;
                        trail_bytes <= 0;
                    end
                end else if (spi_wstrb == 4'h0 && spi_addr == 32'h0) begin
                    spi_rdata <= {24'h0, rx_m};
                end else if (spi_wstrb == 4'h0 && spi_addr == 32'h4) begin
                    spi_rdata <= {31'h0, busy_cnt != 0};
                end else begin
                    bus_viol <= bus_viol + 1;
                end
            end
        end
    end

    // data stream / done monitor
    always @(negedge clk) begin
        if (!resetn) begin
            blk_idx <= 0;
        end else begin
            if (data_valid) begin
                if (data_byte !== 8'(blk_idx)) dv_bad <= dv_bad + 1;
                blk_idx  <= blk_idx + 1;
                dv_total <= dv_total + 1;
            end
            if (done) begin
                done_total <= done_total + 1;
                blk_idx    <= 0;
            end
        end
    end

    task automatic set_slave(input int ra, input logic [7:0] rv, input int ta,
                             input logic [7:0] tv, input logic flip);
        r1_at = ra; r1_val = rv; tok_at = ta; tok_val = tv;
        crc_word = crc16_ref(512) ^ (flip ? 16'h0001 : 16'h0000);
    endtask

    task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [7:0] crc, input logic rd);
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; cmd_crc = crc; cmd_rd_block = rd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [7:0] crc, input logic rd);
        int n;
        issue_cmd(idx, arg, crc, rd);
        n = 0;
        @(negedge clk);
        while (!done && n < 40000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles (cmd %0d)", n, idx);
        end
        got_r1 = r1; got_err = err; got_crc_err = crc_err;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({spi_valid, done, data_valid, crc_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {spi_valid, done, data_valid, crc_err});
        end
        checks++;
        if ({r1, err, spi_addr, spi_wstrb} !== '0) begin
            errors++; $display("FAIL reset_regs: r1=%h err=%0d addr=%h wstrb=%h want zeros", r1, err, spi_addr, spi_wstrb);
        end
    endtask

    task automatic test_cmd0;
        int d0;
        logic [47:0] fr;
        d0 = done_total;
        set_slave(1, 8'h01, -1, 8'hFE, 1'b0);
        run_cmd(6'd0, 32'h0, 8'h95, 1'b0);
        fr = {frame_log[1], frame_log[2], frame_log[3], frame_log[4], frame_log[5], frame_log[6]};
        checks++;
        if (fr !== 48'h40_00_00_00_00_95) begin errors++; $display("FAIL cmd0_frame: got %h want 400000000095", fr); end
        checks++;
        if (frame_log[0] !== 8'hFF) begin errors++; $display("FAIL cmd0_pre: got %h want ff", frame_log[0]); end
        checks++;
        if (got_r1 !== 8'h01 || got_err !== 2'd0) begin
            errors++; $display("FAIL cmd0_status: r1=%h err=%0d want 01/0", got_r1, got_err);
        end
        checks++;
        if (done_total - d0 !== 1) begin errors++; $display("FAIL cmd0_done_count: got %0d want 1", done_total - d0); end
        checks++;
        if (cs_bytes !== 9 || trail_bytes !== 1 || cs_n_m !== 1'b1) begin
            errors++; $display("FAIL cmd0_bytes: cs_bytes=%0d trail=%0d cs_n=%b want 9/1/1", cs_bytes, trail_bytes, cs_n_m);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd0_ready_after: got %b want 1", cmd_ready); end
    endtask

    task automatic test_cmd17_read;
        int v0, b0;
        logic [47:0] fr;
        v0 = dv_total; b0 = dv_bad;
        set_slave(0, 8'h00, 3, 8'hFE, 1'b0);
        run_cmd(6'd17, 32'h0000_0200, 8'h55, 1'b1);
        fr = {frame_log[1], frame_log[2], frame_log[3], frame_log[4], frame_log[5], frame_log[6]};
        checks++;
        if (fr !== 48'h51_00_00_02_00_55) begin errors++; $display("FAIL cmd17_frame: got %h want 510000020055", fr); end
        checks++;
        if (dv_total - v0 !== 512) begin errors++; $display("FAIL cmd17_dv_count: got %0d want 512", dv_total - v0); end
        checks++;
        if (dv_bad - b0 !== 0) begin errors++; $display("FAIL cmd17_data: %0d wrong bytes want 0", dv_bad - b0); end
        checks++;
        if (got_r1 !== 8'h00 || got_err !== 2'd0 || got_crc_err !== 1'b0) begin
            errors++; $display("FAIL cmd17_status: r1=%h err=%0d crc_err=%b want 00/0/0", got_r1, got_err, got_crc_err);
        end
        checks++;
        if (cs_bytes !== 526 || filler_bad !== 0) begin
            errors++; $display("FAIL cmd17_bytes: cs_bytes=%0d filler_bad=%0d want 526/0", cs_bytes, filler_bad);
        end
    endtask

    task automatic test_r1_timeout;
        set_slave(-1, 8'h00, -1, 8'hFE, 1'b0);
        run_cmd(6'd0, 32'h0, 8'h95, 1'b0);
        checks++;
        if (got_err !== 2'd1 || got_r1 !== 8'h00) begin
            errors++; $display("FAIL r1_timeout_status: err=%0d r1=%h want 1/00", got_err, got_r1);
        end
        checks++;
        if (cs_bytes !== 15 || cs_n_m !== 1'b1) begin
            errors++; $display("FAIL r1_timeout_fillers: cs_bytes=%0d cs_n=%b want 15/1", cs_bytes, cs_n_m);
        end
    endtask

    task automatic test_error_token;
        int v0;
        v0 = dv_total;
        set_slave(0, 8'h00, 0, 8'h05, 1'b0);
        run_cmd(6'd17, 32'h0, 8'h55, 1'b1);
        checks++;
        if (got_err !== 2'd3 || got_r1 !== 8'h00) begin
            errors++; $display("FAIL err_token_status: err=%0d r1=%h want 3/00", got_err, got_r1);
        end
        checks++;
        if (dv_total - v0 !== 0 || cs_bytes !== 9) begin
            errors++; $display("FAIL err_token_bytes: dv=%0d cs_bytes=%0d want 0/9", dv_total - v0, cs_bytes);
        end
    endtask

    task automatic test_token_timeout;
        int v0;
        v0 = dv_total;
        set_slave(0, 8'h00, -1, 8'hFE, 1'b0);
        run_cmd(6'd17, 32'h0, 8'h55, 1'b1);
        checks++;
        if (got_err !== 2'd2) begin errors++; $display("FAIL tok_timeout_err: got %0d want 2", got_err); end
        checks++;
        if (cs_bytes !== 1032 || dv_total - v0 !== 0) begin
            errors++; $display("FAIL tok_timeout_fillers: cs_bytes=%0d dv=%0d want 1032/0", cs_bytes, dv_total - v0);
        end
    endtask

    task automatic test_r1_nonzero_skip;
        int v0;
        v0 = dv_total;
        set_slave(0, 8'h05, 0, 8'hFE, 1'b0);
        run_cmd(6'd17, 32'h0, 8'h55, 1'b1);
        checks++;
        if (got_r1 !== 8'h05 || got_err !== 2'd0) begin
            errors++; $display("FAIL r1_skip_status: r1=%h err=%0d want 05/0", got_r1, got_err);
        end
        checks++;
        if (cs_bytes !== 8 || dv_total - v0 !== 0) begin
            errors++; $display("FAIL r1_skip_bytes: cs_bytes=%0d dv=%0d want 8/0", cs_bytes, dv_total - v0);
        end
    endtask

    task automatic test_crc_flip;
        logic exp;
`ifdef SEQ_CRC16_CHECK_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        set_slave(0, 8'h00, 0, 8'hFE, 1'b1);
        run_cmd(6'd17, 32'h0, 8'h55, 1'b1);
        checks++;
        if (got_crc_err !== exp || got_err !== 2'd0) begin
            errors++; $display("FAIL crc_flip: crc_err=%b err=%0d want %b/0", got_crc_err, got_err, exp);
        end
    endtask

    task automatic test_reset_mid_data;
        int v0, n;
        v0 = dv_total;
        set_slave(0, 8'h00, 0, 8'hFE, 1'b0);
        issue_cmd(6'd17, 32'h0, 8'h55, 1'b1);
        n = 0;
        while (dv_total - v0 < 10 && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (dv_total - v0 < 10) begin errors++; $display("FAIL mid_data_reach: dv=%0d want >=10", dv_total - v0); end
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", cmd_ready); end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || spi_valid !== 1'b0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: ready=%b spi_valid=%b dv=%b want 1/0/0", cmd_ready, spi_valid, data_valid);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        set_slave(1, 8'h01, -1, 8'hFE, 1'b0);
        run_cmd(6'd0, 32'h0, 8'h95, 1'b0);
        checks++;
        if (got_r1 !== 8'h01 || got_err !== 2'd0 || cs_bytes !== 9) begin
            errors++; $display("FAIL post_reset_cmd0: r1=%h err=%0d cs_bytes=%0d want 01/0/9", got_r1, got_err, cs_bytes);
        end
    endtask

    task automatic test_bus_rules;
        checks++;
        if (bus_viol !== 0) begin errors++; $display("FAIL bus_rules: %0d bad accesses want 0", bus_viol); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        test_cmd0;
        test_cmd17_read;
        test_r1_timeout;
        test_error_token;
        test_token_timeout;
        test_r1_nonzero_skip;
        test_crc_flip;
        test_reset_mid_data;
        test_bus_rules;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
